// File: rtl/register_dump_unit.sv
// Walks a contiguous, optionally wrapping, register address range through one
// register-file read port and streams {address, data} pairs over valid/ready.
module register_dump_unit #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] first_Addr,
  input  logic [ADDR_WIDTH-1:0] last_Addr,
  output logic [ADDR_WIDTH-1:0] read_Reg_Addr,
  input  logic [DATA_WIDTH-1:0] read_Data,
  output logic                  dump_Valid,
  input  logic                  dump_Ready,
  output logic [ADDR_WIDTH-1:0] dump_Addr,
  output logic [DATA_WIDTH-1:0] dump_Data,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   ptr_q;
  logic [ADDR_WIDTH-1:0]   end_q;
  logic                    valid_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    busy_q;
  logic                    done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      end_q   <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            ptr_q   <= first_Addr;
            end_q   <= last_Addr;
            busy_q  <= 1'b1;
            state_q <= READ;
          end
        end
        READ: begin
          // Snapshot taken here; later writes to the register do not leak in.
          data_q  <= read_Data;
          addr_q  <= ptr_q;
          valid_q <= 1'b1;
          state_q <= HOLD;
        end
        HOLD: begin
          if (dump_Ready) begin
            valid_q <= 1'b0;
            if (ptr_q == end_q) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              ptr_q   <= ptr_q + ADDR_WIDTH'(1);
              state_q <= READ;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign read_Reg_Addr = ptr_q;
  assign dump_Valid    = valid_q;
  assign dump_Addr     = addr_q;
  assign dump_Data     = data_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule
